// File: rtl/audio_rx_if.sv
// audio_rx_if: consumer-side sample pair handshake and status flags
interface audio_rx_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] left, right;
  logic valid, ready, overrun, frame_error, clear_flags;
  modport master(output left, right, valid, overrun, frame_error, input ready, clear_flags);
  modport slave(input left, right, valid, overrun, frame_error, output ready, clear_flags);
endinterface

// File: rtl/audio_rx.sv
// audio_rx: I2S ADC capture, oversampled in clock25mhz, presenting stereo pairs over valid/ready
module audio_rx #(parameter int WIDTH = 16) (
  input logic clock25mhz,
  input logic resetn,
  input logic aud_bclk,
  input logic aud_adclrck,
  input logic aud_adcdat,
  audio_rx_if.master bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {ALIGN, SHIFT, SKIP} state_t;
  state_t state, state_n;
  logic bclk_s1, bclk_s2, bclk_prev, lrck_s1, lrck_s2, dat_s1, dat_s2, lr_prev;
  logic bclk_rise, lr_change, commit, fe_set, chan, chan_n, have_left, pend;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-2:0] shift, shift_n;
  logic [WIDTH-1:0] word, left_hold, pend_l, pend_r;
  assign bclk_rise = bclk_s2 & ~bclk_prev;
  assign lr_change = lrck_s2 ^ lr_prev;
  assign word = {shift, dat_s2};
  always_ff @(posedge clock25mhz or negedge resetn)
    if (!resetn) state <= ALIGN;
    else state <= state_n;
  // the bit on an LRCK-change edge is the I2S delay slot and is never shifted in
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    chan_n = chan;
    shift_n = shift;
    commit = 1'b0;
    fe_set = 1'b0;
    if (bclk_rise && lr_change) begin
      state_n = SHIFT;
      cnt_n = '0;
      chan_n = lrck_s2;
      fe_set = (state == SHIFT);
    end else if (bclk_rise && state == SHIFT) begin
      shift_n = word[WIDTH-2:0];
      cnt_n = cnt + 1'b1;
      commit = (cnt == LAST);
      state_n = commit ? SKIP : SHIFT;
    end
  end
  always_ff @(posedge clock25mhz or negedge resetn)
    if (!resetn) begin
      {bclk_s1, bclk_s2, bclk_prev, lrck_s1, lrck_s2, dat_s1, dat_s2, lr_prev} <= '0;
      cnt <= '0;
      shift <= '0;
      chan <= 1'b0;
      left_hold <= '0;
      have_left <= 1'b0;
      pend <= 1'b0;
      pend_l <= '0;
      pend_r <= '0;
      bus.left <= '0;
      bus.right <= '0;
      bus.valid <= 1'b0;
      bus.overrun <= 1'b0;
      bus.frame_error <= 1'b0;
    end else begin
      {bclk_s2, bclk_s1} <= {bclk_s1, aud_bclk};
      {lrck_s2, lrck_s1} <= {lrck_s1, aud_adclrck};
      {dat_s2, dat_s1} <= {dat_s1, aud_adcdat};
      bclk_prev <= bclk_s2;
      if (bclk_rise) lr_prev <= lrck_s2;
      cnt <= cnt_n;
      shift <= shift_n;
      chan <= chan_n;
      if (commit && !chan) begin
        left_hold <= word;
        have_left <= 1'b1;
      end else if (commit) have_left <= 1'b0;
      pend <= commit & chan & have_left;
      if (commit && chan) begin
        pend_l <= left_hold;
        pend_r <= word;
      end
      // a finished pair is loaded one cycle after the right word commits
      if (pend && (!bus.valid || bus.ready)) begin
        bus.left <= pend_l;
        bus.right <= pend_r;
        bus.valid <= 1'b1;
      end else if (bus.ready) bus.valid <= 1'b0;
      bus.overrun <= (pend & bus.valid & ~bus.ready) | (bus.overrun & ~bus.clear_flags);
      bus.frame_error <= fe_set | (bus.frame_error & ~bus.clear_flags);
    end
endmodule

// File: doc/audio_rx.md
Name: audio_rx

Overview:
- I2S capture block: the receive-side counterpart of the audio DAC path. It deserialises the codec ADC stream (AUD_ADCDAT framed by AUD_ADCLRCK and AUD_BCLK) into stereo sample pairs.
- It runs in the clock25mhz domain and oversamples the codec clocks.
- It presents left/right pairs to a consumer over a valid/ready handshake, with sticky overrun and frame-error flags.

Parameters:
WIDTH, 16, bits per channel word captured (MSB first); extra slot bits are ignored.

Ports:
clock25mhz  input  1  system clock; all state changes on its rising edge.
resetn  input  1  asynchronous, active-low reset.
aud_bclk  input  1  codec bit clock; asynchronous to clock25mhz.
aud_adclrck  input  1  codec LR clock; 0 = left, 1 = right.
aud_adcdat  input  1  codec serial data.
left  output  WIDTH  left sample of the presented pair.
right  output  WIDTH  right sample of the presented pair.
valid  output  1  pair available.
ready  input  1  consumer accepts the pair when valid && ready at a clock edge.
overrun  output  1  sticky: a completed pair was dropped.
frame_error  output  1  sticky: LRCK toggled before WIDTH bits were captured.
clear_flags  input  1  one-cycle pulse that clears overrun and frame_error.

Behaviour:
- Reset (async, resetn=0):
  - left=0, right=0, valid=0, overrun=0, frame_error=0.
  - Synchronisers and the edge-history flop are cleared to 0.
  - FSM=ALIGN, bit counter=0, shift register=0, left_hold=0, have_left=0.
- Synchronisation:
  - aud_bclk, aud_adclrck and aud_adcdat each pass through two flops (s1, s2).
  - A third flop holds the previous s2 of bclk.
  - bclk_rise = s2 & ~prev. All decoding acts only on cycles where bclk_rise=1, using the s2 values of lrck and dat.
- Prior/new LRCK: a register lr_prev holds the s2 lrck seen at the previous bclk_rise. An LRCK change is flagged when the current s2 lrck differs from lr_prev.
- Input constraint: BCLK high and low phases are each ≥3 clock25mhz periods.
- FSM (evaluated on bclk_rise only):
  - ALIGN: ignore data until an LRCK change. On the change, set chan=new lrck, counter=0, go to SHIFT. The data bit on that edge is not captured (I2S one-bit delay slot).
  - SHIFT: shift = {shift[WIDTH-2:0], dat}, counter+1.
    - On the edge where the WIDTH-th bit arrives, the word {shift[WIDTH-2:0], dat} is committed and the FSM goes to SKIP.
    - An LRCK change while in SHIFT discards the partial word, sets frame_error=1, restarts SHIFT for the new channel with counter=0, and leaves have_left unchanged.
  - SKIP: ignore bits until an LRCK change, then behave as ALIGN's transition (chan=new, counter=0, SHIFT).
- Commit:
  - Left word: left_hold=word, have_left=1.
  - Right word with have_left=0: discarded. This covers startup mid-frame.
  - Right word with have_left=1: a pair completes and have_left is cleared.
    - If valid=0, or valid && ready in the same cycle: left=left_hold, right=word, valid=1.
    - Else (valid && !ready): the new pair is dropped, outputs are held, overrun=1.
- Handshake:
  - valid && ready with no pair completing that cycle gives valid=0 next cycle.
  - left/right are stable while valid=1.
- Latency: valid rises on the 3rd clock25mhz edge after s1 captures the BCLK rising edge carrying the right-channel LSB.
- Flags:
  - clear_flags clears both flags.
  - A set event in the same cycle as clear_flags wins; the flag stays 1.
- Counter width is clog2(WIDTH)+1 and never wraps. Slots longer than WIDTH are absorbed in SKIP.

Test Plan:
- Normal stream, 32-bit slots, left=16'hA5C3, right=16'h1234, ready=1 → valid pulses one cycle with left=A5C3, right=1234, 3 clocks after the right LSB edge is captured in s1; flags stay 0.
- Three frames with ready=0 → first pair held unchanged, valid stays 1, overrun=1 after the 2nd frame. Then ready=1 for one cycle → valid=0. clear_flags → overrun=0.
- Stream started mid-right-word after reset → first right word discarded; first valid pair comes from the following complete left+right frame.
- LRCK toggles after 9 bits of a left word → frame_error=1, no pair presented for that frame; next full frame presents correctly.
- resetn asserted mid-SHIFT, then deasserted with stream continuing → all outputs 0 immediately; FSM realigns; first valid pair is the first full frame after an LRCK change.
- ready=1 coincident with a new pair completing while valid=1 → new pair loaded, valid stays 1, overrun remains 0.
